// File: rtl/myswitch_axil_regs.sv
// AXI4-Lite register bank for the switch peripheral: generic RW registers, switch STATUS,
// W1C EVENT, IRQ_EN and a registered interrupt. Define MYSWITCH_DEBOUNCE_EN to add debounce counters.
module myswitch_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_RW_REGS        = 4,
  parameter int SW_WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES    = 16
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [SW_WIDTH-1:0]             sw_in,
  output logic                            irq
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam logic [31:0] IDX_STATUS = 32'(NUM_RW_REGS);
  localparam logic [31:0] IDX_EVENT  = 32'(NUM_RW_REGS + 1);
  localparam logic [31:0] IDX_IRQEN  = 32'(NUM_RW_REGS + 2);

  logic [DW-1:0]       r_regs [NUM_RW_REGS];
  logic [SW_WIDTH-1:0] r_event;
  logic [SW_WIDTH-1:0] r_irq_en;
  logic [SW_WIDTH-1:0] r_sync1;
  logic [SW_WIDTH-1:0] r_sync2;
  logic                r_irq;
  logic                r_awready;
  logic                r_bvalid;
  logic [1:0]          r_bresp;
  logic                r_arready;
  logic                r_rvalid;
  logic [1:0]          r_rresp;
  logic [DW-1:0]       r_rdata;

  logic [SW_WIDTH-1:0] w_deb;
  logic [SW_WIDTH-1:0] w_deb_nxt;
  logic [DW-1:0]       w_wmask;
  logic [DW-1:0]       w_wd_masked;
  logic [31:0]         w_aw_idx;
  logic [31:0]         w_ar_idx;
  logic                w_wr_fire;
  logic                w_rd_fire;
  logic                w_wr_err;
  logic                w_rd_err;
  logic [DW-1:0]       w_rd_data;
  logic [SW_WIDTH-1:0] w_ev_set;
  logic [SW_WIDTH-1:0] w_ev_clr;
  logic                w_unused_ok;

  assign w_unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                         (DEBOUNCE_CYCLES > 0)};

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_awready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RDATA   = r_rdata;
  assign irq           = r_irq;

  assign w_aw_idx  = 32'(S_AXI_AWADDR[AW-1:2]);
  assign w_ar_idx  = 32'(S_AXI_ARADDR[AW-1:2]);
  assign w_wr_fire = r_awready & S_AXI_AWVALID & S_AXI_WVALID;
  assign w_rd_fire = r_arready & S_AXI_ARVALID;
  assign w_wr_err  = (w_aw_idx > IDX_IRQEN);

  always_comb begin
    w_wmask = '0;
    for (int b = 0; b < DW/8; b++) w_wmask[b*8 +: 8] = {8{S_AXI_WSTRB[b]}};
  end
  assign w_wd_masked = S_AXI_WDATA & w_wmask;

  // Switch input synchroniser
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sw_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef MYSWITCH_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0]    r_cnt [SW_WIDTH];
  logic [SW_WIDTH-1:0] r_deb;

  always_comb begin
    w_deb_nxt = r_deb;
    for (int i = 0; i < SW_WIDTH; i++)
      if ((r_sync2[i] != r_deb[i]) && (r_cnt[i] == CNT_LAST)) w_deb_nxt[i] = r_sync2[i];
  end

  // Debounce stage: counter restarts whenever the synchronised level agrees with deb
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_deb <= '0;
      for (int i = 0; i < SW_WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      r_deb <= w_deb_nxt;
      for (int i = 0; i < SW_WIDTH; i++) begin
        if ((r_sync2[i] == r_deb[i]) || (r_cnt[i] == CNT_LAST)) r_cnt[i] <= '0;
        else r_cnt[i] <= r_cnt[i] + CNT_W'(1);
      end
    end
  end
  assign w_deb = r_deb;
`else
  // Without debounce the second synchroniser flop is the debounced level
  assign w_deb     = r_sync2;
  assign w_deb_nxt = r_sync1;
`endif

  assign w_ev_set = w_deb_nxt ^ w_deb;
  assign w_ev_clr = (w_wr_fire && (w_aw_idx == IDX_EVENT)) ? w_wd_masked[SW_WIDTH-1:0] : '0;

  // Register file, event and interrupt state
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int k = 0; k < NUM_RW_REGS; k++) r_regs[k] <= '0;
      r_irq_en <= '0;
      r_event  <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_fire) begin
        for (int k = 0; k < NUM_RW_REGS; k++)
          if (w_aw_idx == 32'(k)) r_regs[k] <= (r_regs[k] & ~w_wmask) | w_wd_masked;
        if (w_aw_idx == IDX_IRQEN)
          r_irq_en <= (r_irq_en & ~w_wmask[SW_WIDTH-1:0]) | w_wd_masked[SW_WIDTH-1:0];
      end
      r_event <= (r_event & ~w_ev_clr) | w_ev_set;
      r_irq   <= |(r_event & r_irq_en);
    end
  end

  // Write channel: AW and W are taken together, never while a response is pending
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
    end else begin
      r_awready <= S_AXI_AWVALID & S_AXI_WVALID & ~r_awready & ~r_bvalid;
      if (w_wr_fire) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_err ? 2'b10 : 2'b00;
      end else if (S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_err  = 1'b0;
    for (int k = 0; k < NUM_RW_REGS; k++)
      if (w_ar_idx == 32'(k)) w_rd_data = r_regs[k];
    if (w_ar_idx == IDX_STATUS) w_rd_data = DW'(w_deb);
    if (w_ar_idx == IDX_EVENT)  w_rd_data = DW'(r_event);
    if (w_ar_idx == IDX_IRQEN)  w_rd_data = DW'(r_irq_en);
    if (w_ar_idx > IDX_IRQEN)   w_rd_err  = 1'b1;
  end

  // Read channel: data captured on the ARREADY handshake edge
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= 2'b00;
      r_rdata   <= '0;
    end else begin
      r_arready <= S_AXI_ARVALID & ~r_arready & ~r_rvalid;
      if (w_rd_fire) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
        r_rresp  <= w_rd_err ? 2'b10 : 2'b00;
      end else if (S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/myswitch_axil_regs.md
# myswitch_axil_regs

AXI4-Lite slave register bank for the switch peripheral. It is the parametrised successor of the fixed four-register myswitch slave. The register count, switch width and debounce length are configurable. It adds synchronised and debounced switch inputs, a write-1-to-clear change-event register, a per-bit interrupt enable with a registered interrupt output, and SLVERR on out-of-range accesses. It sits behind the block-design AXI interconnect and is driven by the AXI VIP master in the IP example bench.

## Interface
- C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; must cover NUM_RW_REGS+3 words.
- NUM_RW_REGS, 4, number of generic read/write registers, 1..16.
- SW_WIDTH, 8, switch input count, 1..32.
- DEBOUNCE_CYCLES, 16, stable cycles required before a debounced bit changes, ≥1.
- ACLK  in  1  single clock.
- ARESET  in  1  reset, asynchronous, active-high.
- S_AXI_AWADDR / AWPROT / AWVALID / AWREADY  in/in/in/out  ADDR/3/1/1  write address channel; AWPROT ignored.
- S_AXI_WDATA / WSTRB / WVALID / WREADY  in/in/in/out  32/4/1/1  write data channel.
- S_AXI_BRESP / BVALID / BREADY  out/out/in  2/1/1  write response.
- S_AXI_ARADDR / ARPROT / ARVALID / ARREADY  in/in/in/out  ADDR/3/1/1  read address; ARPROT ignored.
- S_AXI_RDATA / RRESP / RVALID / RREADY  out/out/out/in  32/2/1/1  read data.
- sw_in  in  SW_WIDTH  asynchronous switch levels.
- irq  out  1  level interrupt.

## Operation
- Word index = ADDR[ADDR_WIDTH-1:2]; ADDR[1:0] ignored.
- Index 0..NUM_RW_REGS-1: REGk, RW, byte-lane writes per WSTRB.
- Index NUM_RW_REGS (STATUS, RO): debounced switch levels, zero-extended. Writes are ignored and return OKAY.
- Index +1 (EVENT, W1C): bit set when the corresponding debounced bit changes level in either direction. Writing 1 clears the bit (WSTRB honoured). If set and clear hit the same cycle, set wins.
- Index +2 (IRQ_EN, RW): low SW_WIDTH bits; upper bits read 0.
- Higher indices: writes are dropped with BRESP=2'b10; reads return RDATA=0 with RRESP=2'b10.
- Sync: a 2-flop synchroniser on each sw_in bit.
- Debounce, per bit: counter clears while sync==deb and increments while sync!=deb. When the counter reaches DEBOUNCE_CYCLES-1 with sync!=deb, deb<=sync and the counter clears.
- irq: registered |(EVENT & IRQ_EN).
- Write and read channels are independent and may complete in the same cycle.

## Timing
- Reset: all READY/VALID low, BRESP/RRESP/RDATA 0, REGk/EVENT/IRQ_EN/deb/sync/counters 0, irq 0. Reset mid-transaction abandons it; no response is issued.
- Write accept: when AWVALID&WVALID&!AWREADY&!BVALID, AWREADY and WREADY both pulse high for exactly one cycle on the next cycle. The register commits on that handshake edge. BVALID rises on the following cycle and holds with a stable BRESP until BREADY.
- AW and W are never accepted separately. A new write is not accepted while BVALID is high.
- Read accept: when ARVALID&!ARREADY&!RVALID, ARREADY pulses for one cycle. RVALID and RDATA are registered the next cycle and held stable until RREADY.
- A read returns the register value as of the ARREADY handshake cycle.
- Switch latency: a sw_in step appears in deb after 2+DEBOUNCE_CYCLES edges. EVENT sets on the same edge deb changes, and irq rises one edge later.
- Glitches shorter than DEBOUNCE_CYCLES never change deb.

## Configuration
- MYSWITCH_DEBOUNCE_EN defined: debounce counters are present, as described above.
- Not defined: no counters and DEBOUNCE_CYCLES is unused. deb equals the synchronised value, so STATUS lags sw_in by 2 cycles, EVENT by 2 and irq by 3.

## Test plan
- Write 0x00000001..0x00000004 to 0x00..0x0C, read back -> identical data, all BRESP/RRESP=OKAY.
- Write 0xAABBCCDD to 0x04 with WSTRB=0b0101 over 0x11223344 -> read 0x11BB33DD.
- With debounce on, sw_in=0x08 held -> STATUS reads 0x08 after 18 cycles and EVENT=0x08. A 10-cycle pulse on sw_in[0] -> STATUS and EVENT unchanged.
- IRQ_EN=0x08 and EVENT[3] set -> irq=1. Write 0x08 to EVENT (0x14) -> EVENT=0 and irq falls the next cycle. If EVENT[3] is written 1 on the same cycle a new change sets it -> EVENT[3] stays 1.
- Read 0x1C -> RDATA=0, RRESP=2'b10. Write 0x1C -> BRESP=2'b10 and no register changes.
- BREADY held low 20 cycles with AWVALID/WVALID pending -> BVALID holds, no second AWREADY until B completes. Assert ARESET mid-read -> all outputs 0 immediately.
